// File: rtl/non_alu_seq_if.sv
// Request / register-read / writeback bundle for the non-ALU instruction sequencer.
// master = environment side (issues requests, serves reads, consumes results); slave = sequencer.
interface non_alu_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_instr;
   logic        rf_rd_en;
   logic [2:0]  rf_rd_reg;
   logic        rf_rd_valid;
   logic [15:0] rf_rd_data;
   logic        wb_valid;
   logic        wb_ready;
   logic [2:0]  wb_reg;
   logic [15:0] wb_data;
   logic        busy;
   logic        err;

   modport master (
      output req_valid, req_instr, rf_rd_valid, rf_rd_data, wb_ready,
      input  req_ready, rf_rd_en, rf_rd_reg, wb_valid, wb_reg, wb_data, busy, err
   );

   modport slave (
      input  req_valid, req_instr, rf_rd_valid, rf_rd_data, wb_ready,
      output req_ready, rf_rd_en, rf_rd_reg, wb_valid, wb_reg, wb_data, busy, err
   );
endinterface

// File: rtl/non_alu_seq.sv
// Sequencer for BTR / LBI / SLBI: optional register read, one-cycle execute, held writeback.
// Optional feature: define NONALU_LBI_BYPASS_EN to send LBI straight from accept to writeback.
module non_alu_seq #(
   parameter int unsigned RD_TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   non_alu_seq_if.slave bus
);

   localparam logic [4:0] OP_BTR  = 5'b11001;
   localparam logic [4:0] OP_LBI  = 5'b11000;
   localparam logic [4:0] OP_SLBI = 5'b10010;
   localparam logic [3:0] CNT_LAST = 4'(RD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_instr;
   logic [15:0] r_operand;
   logic [3:0]  r_cnt;
   logic [15:0] r_wb_data;
   logic [2:0]  r_wb_reg;
   logic        r_wb_valid;
   logic        r_err;
   logic        r_busy;

   logic        w_accept;
   logic [4:0]  w_op;
   logic        w_err_set;
   logic        w_load_wb;
   logic [15:0] w_src_instr;
   logic [18:0] w_result;

   // Returns {destination register, result word}.
   function automatic logic [18:0] f_result(input logic [15:0] instr, input logic [15:0] operand);
      logic [15:0] rev;
      for (int unsigned i = 0; i < 16; i++) begin
         rev[i] = operand[15 - i];
      end
      case (instr[15:11])
         OP_BTR:  f_result = {instr[4:2], rev};
         OP_LBI:  f_result = {instr[10:8], {8{instr[7]}}, instr[7:0]};
         default: f_result = {instr[10:8], operand[7:0], instr[7:0]};
      endcase
   endfunction

   assign w_accept = bus.req_valid && (r_state == S_IDLE);
   assign w_op     = bus.req_instr[15:11];

`ifdef NONALU_LBI_BYPASS_EN
   // Bypassed LBI is evaluated from the request word in its accept cycle.
   assign w_src_instr = (r_state == S_IDLE) ? bus.req_instr : r_instr;
`else
   assign w_src_instr = r_instr;
`endif

   assign w_result = f_result(w_src_instr, r_operand);

   always_comb begin
      w_next_state = r_state;
      w_err_set    = 1'b0;
      w_load_wb    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (w_op)
                  OP_BTR, OP_SLBI: w_next_state = S_READ;
                  OP_LBI: begin
`ifdef NONALU_LBI_BYPASS_EN
                     w_next_state = S_WB;
                     w_load_wb    = 1'b1;
`else
                     w_next_state = S_EXEC;
`endif
                  end
                  default: w_err_set = 1'b1;
               endcase
            end
         end
         S_READ: begin
            // Read data arriving in the last counted cycle beats the timeout.
            if (bus.rf_rd_valid) begin
               w_next_state = S_EXEC;
            end else if (r_cnt == CNT_LAST) begin
               w_next_state = S_IDLE;
               w_err_set    = 1'b1;
            end
         end
         S_EXEC: begin
            w_next_state = S_WB;
            w_load_wb    = 1'b1;
         end
         S_WB: begin
            if (r_wb_valid && bus.wb_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_instr    <= '0;
         r_operand  <= '0;
         r_cnt      <= '0;
         r_wb_data  <= '0;
         r_wb_reg   <= '0;
         r_wb_valid <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_busy     <= (w_next_state != S_IDLE);
         r_err      <= w_err_set;
         r_wb_valid <= (w_next_state == S_WB);
         if (w_accept) begin
            r_instr <= bus.req_instr;
         end
         if (r_state != S_READ) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end
         if ((r_state == S_READ) && bus.rf_rd_valid) begin
            r_operand <= bus.rf_rd_data;
         end
         if (w_load_wb) begin
            r_wb_reg  <= w_result[18:16];
            r_wb_data <= w_result[15:0];
         end
      end
   end

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.rf_rd_en  = (r_state == S_READ);
   assign bus.rf_rd_reg = r_instr[10:8];
   assign bus.wb_valid  = r_wb_valid;
   assign bus.wb_reg    = r_wb_reg;
   assign bus.wb_data   = r_wb_data;
   assign bus.busy      = r_busy;
   assign bus.err       = r_err;

endmodule

// File: doc/non_alu_seq.md
NON_ALU_SEQ -- requirements
Module: non_alu_seq

Interface
REQ-001 Parameter RD_TIMEOUT, default 15, is the max cycles spent waiting for register read data (legal range 1..15).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  request carries a non-ALU instruction.
REQ-005 req_ready  out  1  sequencer can accept a request.
REQ-006 req_instr  in  16  instruction word; opcode is [15:11].
REQ-007 rf_rd_en  out  1  register-file read request.
REQ-008 rf_rd_reg  out  3  read register index (captured instr[10:8]).
REQ-009 rf_rd_valid  in  1  read data valid this cycle.
REQ-010 rf_rd_data  in  16  read data.
REQ-011 wb_valid  out  1  writeback result available.
REQ-012 wb_ready  in  1  writeback consumer accepts result.
REQ-013 wb_reg  out  3  destination register index.
REQ-014 wb_data  out  16  result.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 err  out  1  one-cycle pulse: illegal opcode or read timeout.

Function
REQ-017 FSM states: IDLE, READ, EXEC, WB; req_ready = (state == IDLE).
REQ-018 Handshake: accept when req_valid && req_ready; capture req_instr into an internal register; requests while busy are ignored.
REQ-019 Opcodes: BTR 11001, LBI 11000, SLBI 10010; any other accepted opcode pulses err next cycle, FSM stays IDLE, no writeback.
REQ-020 BTR/SLBI: IDLE -> READ; LBI: IDLE -> EXEC (no register read).
REQ-021 READ: rf_rd_en = 1 and rf_rd_reg = instr[10:8] continuously; on rf_rd_valid latch rf_rd_data and go to EXEC.
REQ-022 READ wait counter cleared on entry; if RD_TIMEOUT cycles elapse without rf_rd_valid, pulse err and return to IDLE; rf_rd_valid in the final counted cycle wins over timeout.
REQ-023 EXEC (one cycle): BTR -> wb_data = bit-reversed operand (bit i -> bit 15-i), wb_reg = instr[4:2]; LBI -> wb_data = sign-extended instr[7:0], wb_reg = instr[10:8]; SLBI -> wb_data = {operand[7:0], instr[7:0]}, wb_reg = instr[10:8]; then go to WB.
REQ-024 WB: wb_valid = 1 with wb_data/wb_reg held stable until wb_ready; on wb_valid && wb_ready return to IDLE the next cycle.
REQ-025 wb_ready while wb_valid = 0 has no effect; rf_rd_valid outside READ is ignored.
REQ-026 Latency (accept cycle N, zero-wait read, wb_ready high): BTR/SLBI wb_valid at N+3, LBI at N+2; back-to-back throughput is one op per 3-4 cycles (no accept while busy).
REQ-027 wb_valid, wb_data, wb_reg, err, busy are registered outputs; rf_rd_en and req_ready decode from state only.

Reset
REQ-028 rst_n low asynchronously forces state IDLE and clears the captured instruction, operand, counter, wb_data, wb_reg, wb_valid, err and busy to 0; req_ready = 1 while in reset.
REQ-029 Reset mid-operation abandons the op: no writeback and no err pulse after release.

Configuration
REQ-030 Macro NONALU_LBI_BYPASS_EN defined: LBI goes IDLE -> WB directly, result computed at accept, wb_valid at N+1.
REQ-031 Macro NONALU_LBI_BYPASS_EN undefined: LBI follows REQ-020/REQ-023 (IDLE -> EXEC -> WB, wb_valid at N+2); all other ops are identical in both builds.

Verification
REQ-032 LBI req_instr 0xC280 (R2, imm 0x80) -> wb_valid at N+2 (N+1 with bypass), wb_reg 2, wb_data 0xFF80.
REQ-033 SLBI 0x93CD, rf_rd_data 0x12AB on first READ cycle -> rf_rd_reg 3, wb_reg 3, wb_data 0xABCD at N+3.
REQ-034 BTR 0xC914, operand 0x0001, wb_ready held low 5 cycles -> wb_reg 5, wb_data 0x8000 stable until wb_ready, then IDLE; req_valid pulsed during WB is not accepted.
REQ-035 Illegal 0xD800 -> err high one cycle, no rf_rd_en, no wb_valid, req_ready stays 1; SLBI with rf_rd_valid never asserted, RD_TIMEOUT 15 -> err after 15 READ cycles, return to IDLE.
REQ-036 rst_n low for 1 cycle while in READ and again while in WB -> all outputs 0 immediately, busy 0, no later wb_valid; next LBI completes normally.
